muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit with architectural HI/LO registers for the cessie MIPS core. Sits directly downstream of instruction decode, alongside the ULA: decode hands it the R-type funct field plus the rs/rt operand values, and the unit executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO are exposed to the writeback path for MFHI/MFLO. `busy` lets the pipeline stall dependent instructions.

---
 rtl/muldiv_unit_pkg.sv | 24 ++
 rtl/muldiv_unit_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the cessie multiply/divide unit: datapath width, bus
// types (bit 0 is the MSB), R-type funct codes and the FSM state encoding.
package types;

  localparam int unsigned WIDTH = 32;

  typedef logic [0:WIDTH-1]   bus_t;
  typedef logic [0:2*WIDTH-1] dbus_t;
  typedef logic [0:5]         funct;

  localparam funct F_MTHI  = 6'h11;
  localparam funct F_MTLO  = 6'h13;
  localparam funct F_MULT  = 6'h18;
  localparam funct F_MULTU = 6'h19;
  localparam funct F_DIV   = 6'h1A;
  localparam funct F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration on the 2*WIDTH accumulator {upper, lower}.
//   div_i=0: shift-add multiply; lower holds the multiplier, b_i the
//            multiplicand, the carry of the add is shifted into the top.
//   div_i=1: restoring divide; lower holds the dividend bits being shifted
//            in and collects quotient bits, upper holds the partial remainder.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               div_i,
  input  logic [0:2*WIDTH-1] acc_i,
  input  logic [0:WIDTH-1]   b_i,
  output logic [0:2*WIDTH-1] acc_o
);

  logic [0:WIDTH-1] up;
  logic [0:WIDTH-1] low;
  logic [0:WIDTH]   sum;
  logic [0:WIDTH]   rem_sh;
  logic [0:WIDTH]   diff;

  assign up  = acc_i[0:WIDTH-1];
  assign low = acc_i[WIDTH:2*WIDTH-1];

  // Single iteration; the partial remainder stays below the divisor, so the
  // MSB of the trial difference is a clean borrow flag.
  always_comb begin
    sum    = {1'b0, up} + (low[WIDTH-1] ? {1'b0, b_i} : '0);
    rem_sh = {up, low[0]};
    diff   = rem_sh - {1'b0, b_i};
    if (div_i) begin
      if (!diff[0]) begin
        acc_o = {diff[1:WIDTH], low[1:WIDTH-1], 1'b1};
      end else begin
        acc_o = {rem_sh[1:WIDTH], low[1:WIDTH-1], 1'b0};
      end
    end else begin
      acc_o = {sum, low[0:WIDTH-2]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is restored in FIX.
// Optional build macro MULDIV_FAST_MULT_EN: multiplies complete in one cycle
// using a native product, division stays iterative.
module muldiv_unit #(
  parameter int unsigned WIDTH = types::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  types::funct      funct,
  input  logic [0:WIDTH-1] rs_val,
  input  logic [0:WIDTH-1] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [0:WIDTH-1] hi,
  output logic [0:WIDTH-1] lo
);
  import types::*;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  muldiv_state_t      state_q;
  logic [0:2*WIDTH-1] acc_q;
  logic [0:2*WIDTH-1] acc_d;
  logic [0:WIDTH-1]   opb_q;
  logic [0:WIDTH-1]   rs_q;
  logic [0:WIDTH-1]   hi_q;
  logic [0:WIDTH-1]   lo_q;
  logic [CW-1:0]      cnt_q;
  logic               div_q;
  logic               q_neg_q;
  logic               r_neg_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_out_q;

  logic               accept;
  logic               op_mult;
  logic               op_div;
  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [0:WIDTH-1]   a_mag;
  logic [0:WIDTH-1]   b_mag;
  logic [0:2*WIDTH-1] prod;
  logic [0:WIDTH-1]   fix_hi;
  logic [0:WIDTH-1]   fix_lo;

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_out_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (div_q),
    .acc_i (acc_q),
    .b_i   (opb_q),
    .acc_o (acc_d)
  );

  // Request decode and operand magnitudes for the accept edge.
  always_comb begin
    accept    = start && !flush && (state_q == IDLE);
    op_mult   = (funct == F_MULT) || (funct == F_MULTU);
    op_div    = (funct == F_DIV)  || (funct == F_DIVU);
    op_signed = (funct == F_MULT) || (funct == F_DIV);
    a_neg     = op_signed && rs_val[0];
    b_neg     = op_signed && rt_val[0];
    a_mag     = a_neg ? -rs_val : rs_val;
    b_mag     = b_neg ? -rt_val : rt_val;
  end

  // Sign correction of the magnitude result; divide-by-zero overrides it.
  // The most-negative / -1 case needs nothing special: negating the
  // unsigned quotient 2^(WIDTH-1) yields the same bit pattern.
  always_comb begin
    prod = q_neg_q ? -acc_q : acc_q;
    if (dz_q) begin
      fix_hi = rs_q;
      fix_lo = '1;
    end else if (div_q) begin
      fix_lo = q_neg_q ? -acc_q[WIDTH:2*WIDTH-1] : acc_q[WIDTH:2*WIDTH-1];
      fix_hi = r_neg_q ? -acc_q[0:WIDTH-1]       : acc_q[0:WIDTH-1];
    end else begin
      fix_hi = prod[0:WIDTH-1];
      fix_lo = prod[WIDTH:2*WIDTH-1];
    end
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [0:2*WIDTH-1] ext_a;
  logic [0:2*WIDTH-1] ext_b;
  logic [0:2*WIDTH-1] fast_prod;

  // Sign-extended operands give the correct 2*WIDTH product for both MULT
  // and MULTU from one unsigned multiply.
  always_comb begin
    ext_a     = {{WIDTH{op_signed & rs_val[0]}}, rs_val};
    ext_b     = {{WIDTH{op_signed & rt_val[0]}}, rt_val};
    fast_prod = ext_a * ext_b;
  end
`endif

  // Control FSM, iteration datapath and HI/LO architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      rs_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (funct == F_MTHI) begin
              hi_q <= rs_val;
            end else if (funct == F_MTLO) begin
              lo_q <= rs_val;
`ifdef MULDIV_FAST_MULT_EN
            end else if (op_mult) begin
              hi_q   <= fast_prod[0:WIDTH-1];
              lo_q   <= fast_prod[WIDTH:2*WIDTH-1];
              done_q <= 1'b1;
`endif
            end else if (op_mult || op_div) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_LAST;
              div_q   <= op_div;
              opb_q   <= op_div ? b_mag : a_mag;
              acc_q   <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              dz_q    <= op_div && (rt_val == '0);
              rs_q    <= rs_val;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            if (cnt_q == '0) begin
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            hi_q     <= fix_hi;
            lo_q     <= fix_lo;
            done_q   <= 1'b1;
            dz_out_q <= dz_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed cases plus
// randomized operations checked against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct    (funct),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour straight from the ISA definition.
  task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      x, y, q, r, p;
    logic [63:0] pu;
    m_dz = 1'b0;
    case (f)
      F_MTHI:  m_hi = a;
      F_MTLO:  m_lo = a;
      F_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = p;
      end
      F_MULTU: begin
        pu = {32'h0, a} * {32'h0, b};
        {m_hi, m_lo} = pu;
      end
      F_DIV, F_DIVU: begin
        if (b == 32'h0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
          m_dz = 1'b1;
        end else if (f == F_DIV) begin
          x = longint'($signed(a));
          y = longint'($signed(b));
          q = x / y;
          r = x % y;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  function automatic int exp_lat(input logic [5:0] f);
`ifdef MULDIV_FAST_MULT_EN
    if (f == F_MULT || f == F_MULTU) return 1;
`endif
    return 34;
  endfunction

  // Called #1 after an edge; start is held for exactly one cycle.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct  = f;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int cyc0, input int lat);
    int cyc;
    cyc = cyc0;
    if (lat > 1) check({tag, " busy"}, busy, 1);
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " latency"}, cyc, lat);
    check({tag, " busy@done"}, busy, 0);
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
    check({tag, " div_zero"}, div_zero, m_dz);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    model_op(f, a, b);
    issue(f, a, b);
    wait_done(tag, 1, exp_lat(f));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 50));
      5:       return 32'h0 - 32'($urandom_range(1, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0]  ops [4];
    logic [31:0] a, b;
    logic [5:0]  f;
    logic        seen;
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct = '0; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset div_zero", div_zero, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mult -3*7", F_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult -3*7 hi const", hi, 32'hFFFF_FFFF);
    check("mult -3*7 lo const", lo, 32'hFFFF_FFEB);
    run_op("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu max hi const", hi, 32'hFFFF_FFFE);
    run_op("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div -7/2 lo const", lo, 32'hFFFF_FFFD);
    run_op("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div ovf lo const", lo, 32'h8000_0000);
    run_op("divu 5/0", F_DIVU, 32'd5, 32'd0);
    check("divu 5/0 hi const", hi, 32'd5);
    @(posedge clk); #1;
    check("done one cycle", done, 0);
    check("div_zero one cycle", div_zero, 0);
    run_op("div -9/0", F_DIV, 32'hFFFF_FFF7, 32'd0);
    run_op("div 7/-2", F_DIV, 32'd7, 32'hFFFF_FFFE);

    // MTHI/MTLO write at the accept edge without busy/done.
    model_op(F_MTHI, 32'hCAFE_0001, 32'h0);
    issue(F_MTHI, 32'hCAFE_0001, 32'h0);
    check("mthi hi", hi, m_hi);
    check("mthi busy", busy, 0);
    check("mthi done", done, 0);
    model_op(F_MTLO, 32'h0000_1234, 32'h0);
    issue(F_MTLO, 32'h0000_1234, 32'h0);
    check("mtlo lo", lo, 32'h0000_1234);

    // Flush of DIVU 10/3 in cycle 10: no done, HI/LO untouched.
    issue(F_DIVU, 32'd10, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("flush no done", seen, 0);
    check("flush lo", lo, 32'h0000_1234);
    check("flush hi", hi, m_hi);

    // Start together with flush from IDLE is dropped.
    start = 1'b1; flush = 1'b1; funct = F_MTHI; rs_val = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start+flush hi", hi, m_hi);

    // Unlisted funct is ignored.
    issue(6'h20, 32'h1111_1111, 32'h2222_2222);
    check("illegal busy", busy, 0);
    @(posedge clk); #1;
    check("illegal done", done, 0);
    check("illegal hi", hi, m_hi);
    check("illegal lo", lo, m_lo);

    // Second start while busy is ignored; first result and timing stand.
    model_op(F_DIVU, 32'd100, 32'd7);
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    issue(F_MULTU, 32'd9, 32'd9);
    wait_done("start in busy", 5, 34);

    // Randomized operations, issued back-to-back in each done cycle.
    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 3)];
      a = pick_val();
      b = pick_val();
      run_op($sformatf("rand%0d f=%h a=%h b=%h", i, f, a, b), f, a, b);
    end

    // Reset in the middle of a divide clears everything immediately.
    issue(F_DIVU, 32'd1000, 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset hi", hi, 0);
    check("midreset lo", lo, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after reset", F_MULT, 32'h7FFF_FFFF, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
